// File: rtl/uart_feed_pkg.sv
// Shared types and constants for the multi-line UART TX feeder.
// Optional CR/LF line terminators are enabled with `define UART_FEED_CRLF_EN.
package uart_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPT,
        ST_NEXT,
        ST_DATA,
        ST_WAIT
`ifdef UART_FEED_CRLF_EN
        , ST_EOL
`endif
    } t_uartfeed_state;

    localparam logic [7:0] c_ascii_space = 8'h20;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;

    // Counter must hold PARM_LINE_LEN itself, hence +1.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_feed_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest request bit plus a none-set flag.
module uart_feed_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         none_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o  = W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_multiline_feed.sv
// Streams the mask-selected lines of a captured ASCII bank to a UART TX, byte by byte
// over valid/ready. `define UART_FEED_CRLF_EN appends 0x0D,0x0A after every line.
module uart_tx_multiline_feed
    import uart_feed_pkg::*;
#(
    parameter int         PARM_LINE_LEN  = 35,
    parameter int         PARM_NUM_LINES = 4,
    parameter logic [7:0] PARM_FILL_CHAR = c_ascii_space
) (
    input  logic                                      i_clk_40mhz,
    input  logic                                      i_rstn_40mhz,
    input  logic                                      i_tx_go,
    input  logic [PARM_NUM_LINES-1:0]                 i_line_mask,
    input  logic [PARM_NUM_LINES*PARM_LINE_LEN*8-1:0] i_dat_ascii_lines,
    output logic [7:0]                                o_tx_data,
    output logic                                      o_tx_valid,
    input  logic                                      i_tx_ready,
    output logic                                      o_busy,
    output logic [idx_width(PARM_NUM_LINES)-1:0]      o_line_idx,
    output logic                                      o_done
);

    localparam int LW = PARM_LINE_LEN * 8;
    localparam int CW = cnt_width(PARM_LINE_LEN);
    localparam int IW = idx_width(PARM_NUM_LINES);

    t_uartfeed_state state_q;
    // Ascending index maps to descending bit position, so line 0 lands in the MS bits.
    logic [0:PARM_NUM_LINES-1][LW-1:0] lines_q;
    logic [PARM_NUM_LINES-1:0]         mask_q;
    logic [PARM_NUM_LINES-1:0]         mask_d;
    logic [LW-1:0]                     shift_q;
    logic [CW-1:0]                     cnt_q;
    logic                              valid_q;
    logic                              done_q;
    logic [IW-1:0]                     idx_q;
    logic [IW-1:0]                     enc_idx;
    logic                              enc_none;
    logic                              hs;

    uart_feed_prio_enc #(
        .N (PARM_NUM_LINES),
        .W (IW)
    ) u_prio_enc (
        .req_i  (mask_q),
        .idx_o  (enc_idx),
        .none_o (enc_none)
    );

    assign mask_d = mask_q & (mask_q - PARM_NUM_LINES'(1));
    assign hs     = valid_q & i_tx_ready;

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            state_q <= ST_IDLE;
            lines_q <= {(PARM_NUM_LINES * PARM_LINE_LEN){PARM_FILL_CHAR}};
            mask_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tx_go) state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    lines_q <= i_dat_ascii_lines;
                    mask_q  <= i_line_mask;
                    state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (enc_none) begin
                        done_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end else begin
                        mask_q  <= mask_d;
                        idx_q   <= enc_idx;
                        shift_q <= lines_q[enc_idx];
                        cnt_q   <= CW'(PARM_LINE_LEN);
                        valid_q <= 1'b1;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        shift_q <= shift_q << 8;
                        cnt_q   <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
`ifdef UART_FEED_CRLF_EN
                            // Reuse the shifter and counter for the two terminator bytes.
                            shift_q[LW-1 -: 16] <= {c_ascii_cr, c_ascii_lf};
                            cnt_q               <= CW'(2);
                            state_q             <= ST_EOL;
`else
                            valid_q <= 1'b0;
                            state_q <= ST_NEXT;
`endif
                        end
                    end
                end
`ifdef UART_FEED_CRLF_EN
                ST_EOL: begin
                    if (hs) begin
                        shift_q <= shift_q << 8;
                        cnt_q   <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            valid_q <= 1'b0;
                            state_q <= ST_NEXT;
                        end
                    end
                end
`endif
                ST_WAIT: begin
                    if (!i_tx_go) state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data  = shift_q[LW-1 -: 8];
    assign o_tx_valid = valid_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_line_idx = idx_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_uart_tx_multiline_feed.sv
// Directed bench for uart_tx_multiline_feed; honours UART_FEED_CRLF_EN when defined.
module tb_uart_tx_multiline_feed;

    localparam int LEN = 35;
    localparam int NL  = 4;
    localparam int LW  = LEN * 8;
`ifdef UART_FEED_CRLF_EN
    localparam int LPB = LEN + 2;
`else
    localparam int LPB = LEN;
`endif

    logic              clk   = 1'b0;
    logic              rstn  = 1'b0;
    logic              go    = 1'b0;
    logic              ready = 1'b0;
    logic [NL-1:0]     mask  = '0;
    logic [NL*LW-1:0]  dat   = '0;
    logic [7:0]        txd;
    logic              txv;
    logic              busy;
    logic              done;
    logic [1:0]        idx;
    logic [NL*LW-1:0]  fill_exp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_multiline_feed dut (
        .i_clk_40mhz       (clk),
        .i_rstn_40mhz      (rstn),
        .i_tx_go           (go),
        .i_line_mask       (mask),
        .i_dat_ascii_lines (dat),
        .o_tx_data         (txd),
        .o_tx_valid        (txv),
        .i_tx_ready        (ready),
        .o_busy            (busy),
        .o_line_idx        (idx),
        .o_done            (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int n, input int b, input logic [7:0] v);
        dat[(NL-1-n)*LW + (LEN-1-b)*8 +: 8] = v;
    endtask

    function automatic logic [7:0] tail_byte(input int off, input logic [7:0] body);
        if (off < LEN) return body;
        return (off == LEN) ? 8'h0D : 8'h0A;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        int first_v, done_at, gaps, errs, idx_err, hold_err, vcnt, dcnt;
        logic pv, pr;
        logic [7:0] pd;
        int line_sel, off;

        for (int n = 0; n < NL; n++)
            for (int b = 0; b < LEN; b++)
                set_byte(n, b, 8'h41 + 8'(n));
        fill_exp = {(NL * LEN){8'h20}};

        // Reset state
        step(); step();
        chk("rst_valid", 32'(txv), 0);
        chk("rst_data", 32'(txd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_idx", 32'(idx), 0);
        #3 rstn = 1'b1;
        step();

        // Basic frame: lines 0 and 2, ready tied high
        mask = 4'b0101; ready = 1'b1; go = 1'b1;
        got.delete(); gaps = 0; first_v = -1; done_at = -1; idx_err = 0;
        for (int s = 1; s <= 300 && done_at < 0; s++) begin
            step();
            if (s == 1) go = 1'b0;
            if (txv) begin
                if (first_v < 0) first_v = s;
                if (idx !== ((got.size() < LPB) ? 2'd0 : 2'd2)) idx_err++;
                got.push_back(txd);
            end else if (got.size() > 0 && got.size() < 2*LPB) begin
                gaps++;
            end
            if (done) done_at = s;
        end
        errs = 0;
        foreach (got[p]) begin
            line_sel = (p < LPB) ? 0 : 2;
            off = p % LPB;
            if (got[p] !== tail_byte(off, 8'h41 + 8'(line_sel))) errs++;
        end
        chk("basic_first_valid", 32'(first_v), 3);
        chk("basic_count", 32'(got.size()), 32'(2*LPB));
        chk("basic_bytes", 32'(errs), 0);
        chk("basic_gap", 32'(gaps), 1);
        chk("basic_done_at", 32'(done_at), 32'(2*LPB + 5));
        chk("basic_idx", 32'(idx_err), 0);
        step();
        chk("basic_done_pulse", 32'(done), 0);
        chk("basic_idle", 32'(busy), 0);

        // Backpressure: ready 1,0,0,1 repeating, line 0 carries distinct bytes
        for (int b = 0; b < LEN; b++) set_byte(0, b, 8'h30 + 8'(b));
        mask = 4'b0001; go = 1'b1;
        got.delete(); hold_err = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00; done_at = -1;
        for (int s = 1; s <= 400 && done_at < 0; s++) begin
            step();
            if (s == 1) go = 1'b0;
            if (pv && !pr && (txv !== 1'b1 || txd !== pd)) hold_err++;
            ready = ((s % 4) == 0) || ((s % 4) == 3);
            if (txv && ready) got.push_back(txd);
            pv = txv; pr = ready; pd = txd;
            if (done) done_at = s;
        end
        errs = 0;
        foreach (got[p]) if (got[p] !== tail_byte(p, 8'h30 + 8'(p))) errs++;
        chk("bp_done_seen", 32'(done_at > 0), 1);
        chk("bp_count", 32'(got.size()), 32'(LPB));
        chk("bp_order", 32'(errs), 0);
        chk("bp_hold", 32'(hold_err), 0);
        ready = 1'b1;
        step();

        // Zero mask
        mask = 4'b0000; go = 1'b1; vcnt = 0; dcnt = 0; done_at = -1;
        for (int s = 1; s <= 6; s++) begin
            step();
            if (s == 1) go = 1'b0;
            if (txv) vcnt++;
            if (done) begin dcnt++; if (done_at < 0) done_at = s; end
            if (s == 4) chk("zero_idle", 32'(busy), 0);
        end
        chk("zero_valid", 32'(vcnt), 0);
        chk("zero_done_at", 32'(done_at), 3);
        chk("zero_done_cnt", 32'(dcnt), 1);

        // Held go: single frame of line 3, FSM parks in WAIT
        mask = 4'b1000; go = 1'b1; got.delete(); idx_err = 0; dcnt = 0;
        for (int s = 1; s <= 200; s++) begin
            step();
            if (txv) begin
                if (idx !== 2'd3) idx_err++;
                got.push_back(txd);
            end
            if (done) dcnt++;
        end
        errs = 0;
        foreach (got[p]) if (got[p] !== tail_byte(p, 8'h44)) errs++;
        chk("held_count", 32'(got.size()), 32'(LPB));
        chk("held_bytes", 32'(errs), 0);
        chk("held_idx", 32'(idx_err), 0);
        chk("held_done_cnt", 32'(dcnt), 1);
        chk("held_wait_busy", 32'(busy), 1);
        go = 1'b0;
        step();
        chk("held_release", 32'(busy), 0);

        // Reset mid-line after ten bytes of line 0 have been accepted
        mask = 4'b0001; go = 1'b1; got.delete();
        for (int s = 1; s <= 100 && got.size() < 10; s++) begin
            step();
            if (s == 1) go = 1'b0;
            if (txv) got.push_back(txd);
        end
        step();
        chk("mid_byte10", 32'(txd), 32'h3A);
        #1 rstn = 1'b0;
        #1;
        chk("mid_async_valid", 32'(txv), 0);
        chk("mid_async_busy", 32'(busy), 0);
        total++;
        assert (dut.lines_q === fill_exp) else begin
            bad++;
            $error("FAIL mid_line_fill: got %h want all 20", dut.lines_q);
        end
        #10 rstn = 1'b1;
        step();
        go = 1'b1;
        step();
        go = 1'b0;
        step();
        step();
        chk("restart_valid", 32'(txv), 1);
        chk("restart_byte0", 32'(txd), 32'h30);
        chk("restart_idx", 32'(idx), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_multiline_feed.md
Name: uart_tx_multiline_feed

Overview:
- Parametrised successor of the single-line UART TX byte feeder.
- Holds a bank of PARM_NUM_LINES ASCII lines of PARM_LINE_LEN bytes each.
- On a go request, streams only the lines selected by a mask, in ascending line order, to the UART TX over a true per-byte valid/ready handshake, so the block never overflows the TX FIFO.
- Sits between the text-generation logic and the UART TX module in the tester top level.

Parameters:
- PARM_LINE_LEN, 35, bytes per line (2..63).
- PARM_NUM_LINES, 4, number of lines in the bank (1..16).
- PARM_FILL_CHAR, 8'h20, byte loaded into the capture registers at reset.

Ports:
- i_clk_40mhz  in  1  system clock, 40 MHz.
- i_rstn_40mhz  in  1  reset; asynchronous, active-low.
- i_tx_go  in  1  level request; starts a frame when seen high in IDLE.
- i_line_mask  in  PARM_NUM_LINES  bit n selects line n; captured at start.
- i_dat_ascii_lines  in  PARM_NUM_LINES*PARM_LINE_LEN*8  line 0 in the MS bits; within each line, byte 0 is the MS byte.
- o_tx_data  out  8  byte to UART TX.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  UART TX accepts a byte when o_tx_valid=1 and i_tx_ready=1 in the same cycle.
- o_busy  out  1  high in every state except IDLE.
- o_line_idx  out  clog2(PARM_NUM_LINES), min 1  index of the line being sent.
- o_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_done=0, o_line_idx=0
  - line registers filled with PARM_FILL_CHAR; remaining-mask=0; byte counter=0.
- States: IDLE, CAPT, NEXT, DATA, WAIT. All outputs are registered or decoded from the state register; no combinational path from the inputs to the outputs.
- IDLE: if i_tx_go=1, go to CAPT.
- CAPT (1 cycle):
  - Register all of i_dat_ascii_lines and i_line_mask into the remaining-mask register.
  - Go to NEXT.
- NEXT (1 cycle):
  - If remaining-mask=0: pulse o_done, go to WAIT.
  - Otherwise take the lowest set bit n, clear it, set o_line_idx=n, load line n into the shift register, set counter=PARM_LINE_LEN, go to DATA.
- DATA:
  - o_tx_valid=1; o_tx_data=MS byte of the shift register.
  - On handshake (valid and ready): shift left 8 bits and decrement the counter.
  - If the counter was 1 at the handshake, go to NEXT.
  - While i_tx_ready=0, o_tx_data and o_tx_valid hold stable.
- WAIT: stay until i_tx_go=0, then go to IDLE. A held go never retriggers a frame.
- Latency: go sampled high in IDLE at cycle 0 gives the first valid byte at cycle 3. Each line costs exactly one NEXT cycle with o_tx_valid=0.
- Counter width: clog2(PARM_LINE_LEN+1). Decrement never wraps; the transition occurs at 1.
- i_dat_ascii_lines and i_line_mask changing after CAPT have no effect on the current frame.
- Mask all-zero: the frame emits no bytes; o_done pulses 2 cycles after CAPT.
- Reset mid-frame: o_tx_valid drops asynchronously; the rest of the frame is discarded.

Optional Feature:
- Macro: UART_FEED_CRLF_EN.
- Defined:
  - Adds state EOL. After the last line byte is accepted, DATA goes to EOL.
  - EOL sends 8'h0D then 8'h0A with the same handshake rules, then goes to NEXT.
  - Each selected line costs PARM_LINE_LEN+2 transfers.
- Undefined:
  - No EOL state; any line terminators must be embedded in the line data.

Decomposition:
- Package uart_feed_pkg:
  - t_uartfeed_state enum.
  - Constants c_ascii_space, c_ascii_cr, c_ascii_lf.
  - Function for counter width.
- Sub-module uart_feed_prio_enc: parametrised lowest-set-bit encoder producing index plus a none-set flag. Used in NEXT.

Test Plan:
- Basic frame: PARM defaults, mask=4'b0101, ready tied 1, lines 0..3 filled with "A".."D" bytes.
  - Expect 70 bytes: 35×0x41 then 35×0x43.
  - Expect exactly one valid-low gap between the two lines.
  - Expect o_done one cycle after NEXT; first valid at cycle 3.
- Backpressure: mask=4'b0001, ready toggles 1,0,0,1 repeating.
  - Expect data to hold stable while ready=0.
  - Expect exactly 35 accepted bytes in order, no duplicates.
- Zero mask: mask=0, go pulse.
  - Expect zero valid cycles, o_done at cycle 3, then IDLE.
- Held go: go high for 200 cycles, mask=4'b1000.
  - Expect one frame only (line 3, o_line_idx=3), with the FSM remaining in WAIT until go falls.
- Reset mid-line: assert i_rstn_40mhz=0 after byte 10 of line 0.
  - Expect o_tx_valid=0 without waiting for a clock edge.
  - After release, expect the IDLE state, line registers all 0x20, and a new go restarting at line byte 0.
- With UART_FEED_CRLF_EN, mask=4'b0011.
  - Expect 74 bytes, each line followed by 0x0D,0x0A.
